mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port 256x32 memory between two requesters: instruction fetch (port F) and load/store (port D).
- One memory access per cycle, granted combinationally in the request cycle.
- Read data is returned through a registered response one cycle after the grant.
- D has priority; a streak limiter guarantees fetch forward progress. A saturating counter records fetch stall cycles for performance monitoring.

Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 32, word width
- MAX_D_STREAK, 4, maximum consecutive D grants while F is waiting
- STALL_CNT_W, 16, width of the fetch stall counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (registered)
- f_rdata  out  DATA_W  fetch read data (registered)
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered); never set for stores
- d_rdata  out  DATA_W  load data (registered)
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory data_in
- mem_write  out  1  to memory write enable
- mem_rdata  in  DATA_W  from memory data_out (combinational read)
- f_stall_cnt  out  STALL_CNT_W  count of cycles with f_req=1 and f_gnt=0, saturating

Behaviour:
- Reset: rst=1 forces the following immediately, independent of clk: f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0, streak=0, f_stall_cnt=0.
- Reset mid-transaction: an access granted in the cycle rst asserts produces no rvalid. Requesters reissue after reset.
- Grant rule (combinational, at most one grant per cycle):
  - d_gnt = d_req & ~(f_req & streak == MAX_D_STREAK)
  - f_gnt = f_req & ~d_gnt
- Memory drive:
  - On d_gnt: mem_addr=d_addr, mem_wdata=d_wdata, mem_write=d_we.
  - On f_gnt: mem_addr=f_addr, mem_write=0.
  - With no grant: mem_write=0 and mem_addr=f_addr.
  - mem_write is never asserted unless d_gnt & d_we.
- Response (one-cycle latency):
  - At posedge, f_rvalid <= f_gnt and d_rvalid <= d_gnt & ~d_we.
  - rdata registers load mem_rdata only when their rvalid sets. Otherwise they hold their previous value.
- Streak counter (width clog2(MAX_D_STREAK+1)):
  - increments on d_gnt & f_req;
  - clears on f_gnt or when f_req=0;
  - never exceeds MAX_D_STREAK.
- Simultaneous requests: D wins unless streak == MAX_D_STREAK. In that case F wins that cycle and the streak clears.
- Back-to-back: a requester may hold its request across cycles. Each granted cycle is an independent access, so two loads in consecutive cycles give d_rvalid in both following cycles.
- Store then load to the same address in consecutive cycles: the load returns the stored value. Memory writes at the posedge and reads combinationally next cycle.
- f_stall_cnt increments each cycle with f_req & ~f_gnt and saturates at all-ones, with no wrap.
- Requesters must keep request, address and data stable while req is high and gnt is low. The arbiter does not latch request fields.

Decomposition:
- Shared package mem_pkg holds ADDR_W=8, DATA_W=32, and localparams PORT_F=0 and PORT_D=1 for monitors.
- Natural sub-module sat_counter (parameter WIDTH; ports clk, rst, inc, clr, max, count):
  - used for the streak counter with max = MAX_D_STREAK;
  - used for f_stall_cnt with max = all-ones and clr tied to 0.
- Grant, mux and response logic stay in mem_port_arbiter.

Test Plan:
- Reset mid-activity: d_req=1, d_we=0, rst pulsed asynchronously between edges -> d_rvalid and f_rvalid go to 0 immediately; f_stall_cnt=0; streak=0.
- Fetch only: f_req=1, f_addr=0x10, mem[0x10]=0xDEADBEEF -> f_gnt=1 same cycle; next cycle f_rvalid=1 and f_rdata=0xDEADBEEF; d_rvalid stays 0.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x12345678, then d_we=0 to 0x20 -> mem_write=1 only in cycle 1, no d_rvalid after the store; d_rvalid=1 and d_rdata=0x12345678 after the load.
- Starvation limit: f_req and d_req held high for 12 cycles, MAX_D_STREAK=4 -> grant pattern D,D,D,D,F repeating; f_stall_cnt=10 after 12 cycles.
- Fetch-only contention: d_req=1 with f_req=0 for 8 cycles, then f_req=1 -> D is granted all 8 cycles with the streak held at 0; F stalls until the streak reaches 4.
- Saturation: STALL_CNT_W=4, F starved by forced contention for 20 stall cycles -> f_stall_cnt=15 and holds there.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and port identifiers for the memory port arbiter slice.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int PORT_F = 0;
  localparam int PORT_D = 1;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } d_req_t;
endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                        count_d = '0;
    else if (inc && count_q != max) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else     count_q <= count_d;

  assign count = count_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-port memory: D has priority, a streak limit
// guarantees fetch progress, read data comes back registered one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W       = mem_pkg::ADDR_W,
  parameter int DATA_W       = mem_pkg::DATA_W,
  parameter int MAX_D_STREAK = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_req,
  input  logic [ADDR_W-1:0]      f_addr,
  output logic                   f_gnt,
  output logic                   f_rvalid,
  output logic [DATA_W-1:0]      f_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_W-1:0]      d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [DATA_W-1:0]      d_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_write,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [STALL_CNT_W-1:0] f_stall_cnt
);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                streak_full;
  logic                f_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   f_rdata_q, d_rdata_q;

  assign streak_full = (streak == STREAK_MAX);
  assign d_gnt       = d_req & ~(f_req & streak_full);
  assign f_gnt       = f_req & ~d_gnt;

  // Idle cycles park the address on the fetch port.
  always_comb begin
    mem_addr  = f_addr;
    mem_wdata = d_wdata;
    mem_write = 1'b0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_write = d_we;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt & ~d_we;
      if (f_gnt)          f_rdata_q <= mem_rdata;
      if (d_gnt && !d_we) d_rdata_q <= mem_rdata;
    end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

  // The streak only measures D wins while F is actually waiting.
  sat_counter #(.WIDTH(STREAK_W)) u_streak (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_gnt & f_req),
    .clr   (f_gnt | ~f_req),
    .max   (STREAK_MAX),
    .count (streak)
  );

  sat_counter #(.WIDTH(STALL_CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (f_req & ~f_gnt),
    .clr   (1'b0),
    .max   ({STALL_CNT_W{1'b1}}),
    .count (f_stall_cnt)
  );
endmodule
